// File: rtl/md5_msg_padder_if.sv
// Byte-stream input and padded-block output bundle for the md5 message padder.
interface md5_msg_padder_if;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        in_last_i;
  logic        in_empty_i;
  logic        in_ready_o;
  logic [31:0] M_o [0:15];
  logic        blk_valid_o;
  logic        blk_last_o;
  logic        blk_ready_i;
  logic        busy_o;

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, in_empty_i, blk_ready_i,
    output in_ready_o, M_o, blk_valid_o, blk_last_o, busy_o
  );

  modport master (
    output in_data_i, in_valid_i, in_last_i, in_empty_i, blk_ready_i,
    input  in_ready_o, M_o, blk_valid_o, blk_last_o, busy_o
  );
endinterface

// File: rtl/md5_msg_padder.sv
// md5 message padder: packs a byte stream into 512-bit blocks of sixteen
// little-endian words, appending the 0x80 terminator, zero fill and the
// 64-bit bit-length trailer (plus an extra block when the trailer won't fit).
module md5_msg_padder #(
  parameter int CNT_W = 61
) (
  input  logic            clk_i,
  input  logic            rst_i,
  md5_msg_padder_if.slave bus
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  state_t             r_after;
  state_t             w_after_nxt;
  logic [5:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_m [0:15];
  logic               r_last;
  logic               w_accept;
  logic               w_wr_byte;
  logic [63:0]        w_bitlen;

  // Message length in bits, wrapping modulo 2^64.
  function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] cnt);
    logic [CNT_W+2:0] full;
    full = {cnt, 3'b000};
    return 64'(full);
  endfunction

  assign w_bitlen        = bit_len(r_cnt);
  assign bus.in_ready_o  = rst_i && (r_state == FILL);
  assign bus.blk_valid_o = (r_state == EMIT);
  assign bus.blk_last_o  = r_last;
  assign bus.busy_o      = (r_state != FILL) || (r_idx != 6'd0) || (r_cnt != '0);
  assign bus.M_o         = r_m;

  // State and return-state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= FILL;
      r_after <= FILL;
    end else begin
      r_state <= w_state_nxt;
      r_after <= w_after_nxt;
    end
  end

  // Next-state selection; EMIT returns to whichever state was queued in r_after.
  always_comb begin
    w_state_nxt = r_state;
    w_after_nxt = r_after;
    w_accept    = bus.in_valid_i && (r_state == FILL);
    w_wr_byte   = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          if (bus.in_last_i && bus.in_empty_i) begin
            w_state_nxt = PAD;
          end else begin
            w_wr_byte = 1'b1;
            if (bus.in_last_i && (r_idx == 6'd63)) begin
              w_state_nxt = EMIT;
              w_after_nxt = PAD;
            end else if (bus.in_last_i) begin
              w_state_nxt = PAD;
            end else if (r_idx == 6'd63) begin
              w_state_nxt = EMIT;
              w_after_nxt = FILL;
            end
          end
        end
      end
      PAD: begin
        if (r_idx <= 6'd55) begin
          w_state_nxt = LEN;
        end else begin
          w_state_nxt = EMIT;
          w_after_nxt = LEN;
        end
      end
      LEN: begin
        w_state_nxt = EMIT;
        w_after_nxt = FILL;
      end
      EMIT: begin
        if (bus.blk_ready_i) begin
          w_state_nxt = r_after;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Block buffer, byte position, byte counter and final-block flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idx  <= 6'd0;
      r_cnt  <= '0;
      r_last <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        r_m[k] <= 32'd0;
      end
    end else begin
      case (r_state)
        FILL: begin
          if (w_wr_byte) begin
            r_m[r_idx[5:2]][{r_idx[1:0], 3'b000} +: 8] <= bus.in_data_i;
            r_idx <= r_idx + 6'd1;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PAD: begin
          r_m[r_idx[5:2]][{r_idx[1:0], 3'b000} +: 8] <= 8'h80;
          r_idx <= r_idx + 6'd1;
        end
        LEN: begin
          r_m[14] <= w_bitlen[31:0];
          r_m[15] <= w_bitlen[63:32];
          r_last  <= 1'b1;
        end
        EMIT: begin
          // Clearing on handshake is what provides the zero fill of the next block.
          if (bus.blk_ready_i) begin
            for (int k = 0; k < 16; k++) begin
              r_m[k] <= 32'd0;
            end
            r_idx <= 6'd0;
            if (r_last) begin
              r_cnt  <= '0;
              r_last <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// Bench for md5_msg_padder: directed RFC 1321 padding cases plus randomized
// messages, checked against a byte-array padding model.
module tb_md5_msg_padder;

  typedef logic [7:0] u8;
  typedef struct packed {
    logic         last;
    logic [511:0] d;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md5_msg_padder_if bus();

  md5_msg_padder #(.CNT_W(61)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  blk_t         exp_q[$];
  int           rise_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           rdy_mode = 0;
  int           last_acc_cyc = 0;
  int           cap_n = 0;
  logic [511:0] cap_d [0:1023];
  logic         cap_l [0:1023];
  logic         prev_valid = 1'b0;
  logic [511:0] dd;

  always @(posedge clk) cyc <= cyc + 1;

  // Block-ready driver: always high, random, or held low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.blk_ready_i = 1'b1;
      1:       bus.blk_ready_i = ($urandom_range(0, 2) != 0);
      default: bus.blk_ready_i = 1'b0;
    endcase
  end

  // Padding model: message bytes, 0x80, zeros to 56 mod 64, 64-bit LE bit length.
  function automatic void model_blocks(input u8 m[$], output blk_t q[$]);
    u8           p[$];
    logic [63:0] bl;
    int          nb;
    blk_t        t;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    q = {};
    for (int b = 0; b < nb; b++) begin
      t.d = '0;
      for (int i = 0; i < 64; i++) t.d[8*i +: 8] = p[64*b + i];
      t.last = (b == nb - 1);
      q.push_back(t);
    end
  endfunction

  task automatic push_expected(input u8 m[$]);
    blk_t q[$];
    model_blocks(m, q);
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] cw(input int b, input int k);
    return cap_d[b][32*k +: 32];
  endfunction

  task automatic ck_zero(input string nm, input int b, input logic [15:0] skip);
    for (int k = 0; k < 16; k++)
      if (!skip[k]) ck($sformatf("%s_w%0d", nm, k), 64'(cw(b, k)), 64'd0);
  endtask

  // Compare process: every cycle a block is offered it must equal the model's head.
  always @(negedge clk) begin
    for (int k = 0; k < 16; k++) dd[32*k +: 32] = bus.M_o[k];
    if (rst_n && bus.blk_valid_o) begin
      if (!prev_valid) rise_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block: got valid=1 expected no block");
      end else if (dd !== exp_q[0].d || bus.blk_last_o !== exp_q[0].last) begin
        errors++;
        for (int k = 0; k < 16; k++)
          if (dd[32*k +: 32] !== exp_q[0].d[32*k +: 32]) begin
            $display("FAIL block_word%0d: got %08h expected %08h (last got %0b expected %0b)",
                     k, dd[32*k +: 32], exp_q[0].d[32*k +: 32], bus.blk_last_o, exp_q[0].last);
            break;
          end
        if (dd === exp_q[0].d)
          $display("FAIL block_last: got %0b expected %0b", bus.blk_last_o, exp_q[0].last);
      end
      checks++;
      if (bus.in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_during_emit: got %0b expected 0", bus.in_ready_o);
      end
      if (bus.blk_ready_i) begin
        cap_d[cap_n % 1024] = dd;
        cap_l[cap_n % 1024] = bus.blk_last_o;
        cap_n++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    prev_valid = rst_n && bus.blk_valid_o;
  end

  // mode 0: last on final byte; 1: empty last beat after the bytes; 2: no last beat.
  task automatic send(input u8 m[$], input int mode, input bit model, input bit gaps);
    int n, beats, t, acc;
    bit ok;
    if (model) push_expected(m);
    n = m.size();
    beats = (mode == 1) ? n + 1 : n;
    @(posedge clk); #1;
    for (int b = 0; b < beats; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.in_valid_i = 1'b1;
      if (b < n) begin
        bus.in_data_i  = m[b];
        bus.in_last_i  = (mode == 0) && (b == n - 1);
        bus.in_empty_i = bus.in_last_i ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        bus.in_data_i  = 8'($urandom);
        bus.in_last_i  = 1'b1;
        bus.in_empty_i = 1'b1;
      end
      t = 0; ok = 1'b0; acc = 0;
      while (!ok && t < 3000) begin
        @(negedge clk);
        ok = bus.in_ready_o;
        acc = cyc;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL beat_accept_timeout: got no accept expected accept within 3000 cycles");
      end
      last_acc_cyc = acc;
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    bus.in_empty_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    logic [511:0] z;
    for (int k = 0; k < 16; k++) z[32*k +: 32] = bus.M_o[k];
    ck({nm, "_M_any"}, 64'(|z), 64'd0);
    ck({nm, "_valid"}, 64'(bus.blk_valid_o), 64'd0);
    ck({nm, "_last"}, 64'(bus.blk_last_o), 64'd0);
    ck({nm, "_in_ready"}, 64'(bus.in_ready_o), 64'd0);
    ck({nm, "_busy"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    u8            m[$];
    u8            abc[$];
    blk_t         mq[$];
    int           base, len, t;
    logic [511:0] snap, cur;

    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 8'h00;
    bus.in_last_i   = 1'b0;
    bus.in_empty_i  = 1'b0;
    bus.blk_ready_i = 1'b1;
    abc = '{8'h61, 8'h62, 8'h63};

    // Model pins against hand-computed values.
    model_blocks(abc, mq);
    ck("model_abc_nblk", 64'(mq.size()), 64'd1);
    ck("model_abc_w0", 64'(mq[0].d[31:0]), 64'h80636261);
    ck("model_abc_w14", 64'(mq[0].d[32*14 +: 32]), 64'h18);
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'h41);
    model_blocks(m, mq);
    ck("model_56_nblk", 64'(mq.size()), 64'd2);
    ck("model_56_b0w14", 64'(mq[0].d[32*14 +: 32]), 64'h80);
    ck("model_56_b1w14", 64'(mq[1].d[32*14 +: 32]), 64'h1C0);

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    ck("idle_in_ready", 64'(bus.in_ready_o), 64'd1);

    // "abc" with ready held high.
    rdy_mode = 0;
    base = cap_n; rise_q = {};
    send(abc, 0, 1, 0);
    drain();
    ck("abc_nblk", 64'(cap_n - base), 64'd1);
    ck("abc_w0", 64'(cw(base, 0)), 64'h80636261);
    ck("abc_w14", 64'(cw(base, 14)), 64'h18);
    ck_zero("abc", base, 16'h4001);
    ck("abc_last", 64'(cap_l[base]), 64'd1);
    ck("abc_nrise", 64'(rise_q.size()), 64'd1);
    if (rise_q.size() >= 1) ck("abc_latency", 64'(rise_q[0] - last_acc_cyc), 64'd3);
    ck("abc_busy_after", 64'(bus.busy_o), 64'd0);

    // Empty message.
    base = cap_n;
    m = {};
    send(m, 1, 1, 0);
    drain();
    ck("empty_nblk", 64'(cap_n - base), 64'd1);
    ck("empty_w0", 64'(cw(base, 0)), 64'h80);
    ck_zero("empty", base, 16'h0001);
    ck("empty_last", 64'(cap_l[base]), 64'd1);

    // 55 bytes: trailer just fits.
    base = cap_n;
    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h41);
    send(m, 0, 1, 0);
    drain();
    ck("b55_nblk", 64'(cap_n - base), 64'd1);
    ck("b55_w13", 64'(cw(base, 13)), 64'h80414141);
    ck("b55_w14", 64'(cw(base, 14)), 64'h1B8);
    ck("b55_last", 64'(cap_l[base]), 64'd1);

    // 56 bytes: trailer spills into a second block.
    base = cap_n;
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'h41);
    send(m, 0, 1, 0);
    drain();
    ck("b56_nblk", 64'(cap_n - base), 64'd2);
    ck("b56_b0w14", 64'(cw(base, 14)), 64'h80);
    ck("b56_b0w15", 64'(cw(base, 15)), 64'h0);
    ck("b56_b0last", 64'(cap_l[base]), 64'd0);
    ck("b56_b1w14", 64'(cw(base + 1, 14)), 64'h1C0);
    ck_zero("b56_b1", base + 1, 16'h4000);
    ck("b56_b1last", 64'(cap_l[base + 1]), 64'd1);

    // 64 zero bytes: full data block then a padding-only block.
    base = cap_n; rise_q = {};
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'h00);
    send(m, 0, 1, 0);
    drain();
    ck("b64_nblk", 64'(cap_n - base), 64'd2);
    ck_zero("b64_b0", base, 16'h0000);
    ck("b64_b0last", 64'(cap_l[base]), 64'd0);
    ck("b64_b1w0", 64'(cw(base + 1, 0)), 64'h80);
    ck("b64_b1w14", 64'(cw(base + 1, 14)), 64'h200);
    ck("b64_b1last", 64'(cap_l[base + 1]), 64'd1);
    ck("b64_nrise", 64'(rise_q.size()), 64'd2);
    if (rise_q.size() >= 2) begin
      ck("b64_lat_full", 64'(rise_q[0] - last_acc_cyc), 64'd1);
      ck("b64_lat_second", 64'(rise_q[1] - rise_q[0]), 64'd3);
    end

    // Backpressure: block held for 5 cycles, then taken.
    rdy_mode = 2;
    @(posedge clk); #2;
    base = cap_n;
    send(abc, 0, 1, 0);
    t = 0;
    while (!bus.blk_valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    ck("bp_valid_rise", 64'(bus.blk_valid_o), 64'd1);
    for (int k = 0; k < 16; k++) snap[32*k +: 32] = bus.M_o[k];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) cur[32*k +: 32] = bus.M_o[k];
      ck($sformatf("bp_valid_%0d", i), 64'(bus.blk_valid_o), 64'd1);
      ck($sformatf("bp_in_ready_%0d", i), 64'(bus.in_ready_o), 64'd0);
      ck($sformatf("bp_hold_%0d", i), 64'(cur === snap), 64'd1);
    end
    ck("bp_nblk_before", 64'(cap_n - base), 64'd0);
    rdy_mode = 0;
    drain();
    ck("bp_nblk", 64'(cap_n - base), 64'd1);
    ck("bp_w0", 64'(cw(base, 0)), 64'h80636261);
    ck("bp_last", 64'(cap_l[base]), 64'd1);

    // Reset in the middle of a message discards it.
    m = {};
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
    send(m, 2, 0, 0);
    @(negedge clk);
    ck("mid_busy", 64'(bus.busy_o), 64'd1);
    ck("mid_M0", 64'(bus.M_o[0]), {32'd0, m[3], m[2], m[1], m[0]});
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    base = cap_n;
    send(abc, 0, 1, 0);
    drain();
    ck("post_rst_nblk", 64'(cap_n - base), 64'd1);
    ck("post_rst_w0", 64'(cw(base, 0)), 64'h80636261);
    ck("post_rst_w14", 64'(cw(base, 14)), 64'h18);

    // Randomized messages, random block backpressure and input gaps.
    rdy_mode = 1;
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(0, 3);
        1:       len = 55 + $urandom_range(0, 10);
        2:       len = 119 + $urandom_range(0, 10);
        default: len = $urandom_range(0, 200);
      endcase
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send(m, (len == 0) ? 1 : int'($urandom_range(0, 1)), 1, 1);
    end
    drain();
    ck("rand_busy_after", 64'(bus.busy_o), 64'd0);
    ck("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
